// File: rtl/mips_multicycle_ctrl_pkg.sv
// mips_multicycle_ctrl_pkg: state codes, opcode/funct constants, ALU and mux encodings for the multicycle MIPS control FSM
package mips_multicycle_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_BNE    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Unsupported opcodes map to FETCH; the caller treats that as an illegal exit.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t s;
        case (op)
            OP_LW, OP_SW: s = S_MEMADR;
            OP_RTYPE:     s = S_EXEC;
            OP_BEQ:       s = S_BEQ;
            OP_BNE:       s = S_BNE;
            OP_ADDI:      s = S_ADDIEX;
            OP_J:         s = S_JUMP;
            default:      s = S_FETCH;
        endcase
        return s;
    endfunction
endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: combinational Funct + ALUOp -> ALUControl, with funct_valid flag
// Ports:
//   funct        in  6  IR[5:0]
//   alu_op       in  2  00=add, 01=sub, 10=use funct
//   alu_control  out 3  ALU operation code
//   funct_valid  out 1  funct is a supported R-type function
module mips_alu_decoder
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control,
    output logic       funct_valid
);
    logic [2:0] f_ctl;

    always_comb begin
        f_ctl       = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            F_ADD:   f_ctl = ALU_ADD;
            F_SUB:   f_ctl = ALU_SUB;
            F_AND:   f_ctl = ALU_AND;
            F_OR:    f_ctl = ALU_OR;
            F_SLT:   f_ctl = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
        alu_control = alu_op == ALUOP_SUB   ? ALU_SUB :
                      alu_op == ALUOP_FUNCT ? f_ctl   : ALU_ADD;
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM for the multicycle MIPS datapath
// Optional feature macro: MC_SINGLE_STEP_EN adds a Step input that gates each fetch.
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   Op, Funct, Zero   IR opcode/funct fields and ALU zero flag
//   Step              (MC_SINGLE_STEP_EN only) one-cycle pulse releasing one fetch
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
//   ALUControl, PCSrc, PCEn   datapath mux selects and write enables
//   State             current FSM state code
//   RetiredCnt        instructions completed since reset (wraps)
//   IllegalOp         sticky flag: unsupported opcode/funct decoded
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int STATE_W = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
`ifdef MC_SINGLE_STEP_EN
    input  logic               Step,
`endif
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [1:0]         PCSrc,
    output logic               PCEn,
    output logic [STATE_W-1:0] State,
    output logic [CNT_W-1:0]   RetiredCnt,
    output logic               IllegalOp
);
    state_t           state, next;
    logic             pc_write, branch, branch_ne, ir_write, mem_write, reg_write;
    logic             illegal_exit, funct_valid, go;
    logic [1:0]       alu_op;
    logic [CNT_W-1:0] cnt;
    logic             ill;

`ifdef MC_SINGLE_STEP_EN
    assign go = Step;
`else
    assign go = 1'b1;
`endif

    mips_alu_decoder u_alu_dec (
        .funct       (Funct),
        .alu_op      (alu_op),
        .alu_control (ALUControl),
        .funct_valid (funct_valid)
    );

    always_comb begin
        next         = state;
        IorD         = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_B;
        PCSrc        = PC_ALU;
        alu_op       = ALUOP_ADD;
        pc_write     = 1'b0;
        branch       = 1'b0;
        branch_ne    = 1'b0;
        ir_write     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        illegal_exit = 1'b0;
        case (state)
            S_FETCH: if (go) begin
                ir_write = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                pc_write = 1'b1;
                next     = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB      = SRCB_IMMSH;
                next         = decode_next(Op);
                illegal_exit = decode_next(Op) == S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                next    = Op == OP_LW ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                next = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
                next      = S_FETCH;
            end
            S_MEMWR: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
                next      = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA      = 1'b1;
                alu_op       = ALUOP_FUNCT;
                next         = funct_valid ? S_ALUWB : S_FETCH;
                illegal_exit = ~funct_valid;
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
                next      = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA   = 1'b1;
                alu_op    = ALUOP_SUB;
                PCSrc     = PC_ALUOUT;
                branch    = state == S_BEQ;
                branch_ne = state == S_BNE;
                next      = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                next      = S_FETCH;
            end
            S_JUMP: begin
                PCSrc    = PC_JUMP;
                pc_write = 1'b1;
                next     = S_FETCH;
            end
            default: next = S_FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_FETCH;
            cnt   <= '0;
            ill   <= 1'b0;
        end else begin
            state <= next;
            if (illegal_exit)
                ill <= 1'b1;
            if (state != S_FETCH && next == S_FETCH && !illegal_exit)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // State-changing enables are suppressed while reset is held so an
    // interrupted instruction cannot commit a write.
    assign IRWrite    = ir_write & ~Rst;
    assign MemWrite   = mem_write & ~Rst;
    assign RegWrite   = reg_write & ~Rst;
    assign PCEn       = ~Rst & (pc_write | (branch & Zero) | (branch_ne & ~Zero));
    assign State      = STATE_W'(state);
    assign RetiredCnt = cnt;
    assign IllegalOp  = ill;
endmodule
